// File: rtl/load_store_unit.sv
// Memory stage: drives the data-memory request/grant/response handshake
// and returns lane-extracted, extended load results to writeback.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [2:0]         funct3,
    input  logic [WIDTH-1:0]   ALUResult,
    input  logic [WIDTH-1:0]   WriteData,
    input  logic [4:0]         rd,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_be,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [WIDTH-1:0]   wb_data,
    output logic               fault
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]         state;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [4:0]         rd_q;
    logic               accept;
    logic               unsupported;
    logic               misaligned;
    logic               bad;
    logic [WIDTH/8-1:0] be_n;
    logic [WIDTH-1:0]   wdata_n;
    logic [7:0]         lbyte;
    logic [15:0]        lhalf;
    logic               sext;
    logic [WIDTH-1:0]   ldata;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready & (MemRead | MemWrite);

    // 011/111 via the low bits, 110 explicitly; stores have no unsigned forms
    assign unsupported = (funct3[1:0] == 2'b11)
                       | (funct3 == 3'b110)
                       | (MemWrite & funct3[2]);

    assign misaligned = ((funct3[1:0] == 2'b01) & ALUResult[0])
                      | ((funct3[1:0] == 2'b10) & (|ALUResult[1:0]));

    assign bad = unsupported | misaligned;

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = WriteData;
        case (funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << ALUResult[1:0];
                wdata_n = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << ALUResult[1:0];
                wdata_n = {2{WriteData[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = WriteData;
            end
        endcase
    end

    always_comb begin
        lbyte = mem_rdata[{off_q, 3'b000} +: 8];
        lhalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        sext  = ~f3_q[2];
        ldata = '0;
        unique case (1'b1)
            f3_q[1]: ldata = mem_rdata;
            f3_q[0]: ldata = {{(WIDTH-16){lhalf[15] & sext}}, lhalf};
            default: ldata = {{(WIDTH-8){lbyte[7] & sext}}, lbyte};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            fault     <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            rd_q      <= '0;
        end else begin
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            fault <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {ALUResult[WIDTH-1:2], 2'b00};
                            mem_wdata <= wdata_n;
                            mem_be    <= be_n;
                            f3_q      <= funct3;
                            off_q     <= ALUResult[1:0];
                            rd_q      <= rd;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_we ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= ldata;
                        wb_rd    <= rd_q;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases then random traffic
// against a byte-addressed memory model with randomized grant/response delays.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  rd = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult),
        .WriteData(WriteData), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    req_t reqq[$];
    wb_t  wbq[$];
    int   faultq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gnt_cfg = -1;
    int rv_cfg = -1;
    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] memword(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Reference: derived from access size and byte offset with plain arithmetic
    task automatic model(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] r);
        int size;
        int off;
        bit legal;
        bit sgn;
        req_t q;
        wb_t w;
        logic [31:0] v;
        if (!mr && !mw) return;
        off = int'(a % 4);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        sgn = (f3[2] == 1'b0);
        if (mw) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                      f3 == 3'd4 || f3 == 3'd5);
        if (!legal || (off % size) != 0) begin
            faultq.push_back(1);
            return;
        end
        q.we = mw;
        q.addr = a - 32'(off);
        q.be = 4'(((1 << size) - 1) << off);
        if (size == 1) q.wdata = {24'h0, wd[7:0]} * 32'h01010101;
        else if (size == 2) q.wdata = {16'h0, wd[15:0]} * 32'h00010001;
        else q.wdata = wd;
        reqq.push_back(q);
        if (mr) begin
            v = memword(q.addr) >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (sgn && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v - 32'd65536;
            end
            w.rd = r;
            w.data = v;
            wbq.push_back(w);
        end
    endtask

    // Memory responder
    int gcnt = -1;
    int rcnt = 0;
    bit pend = 0;
    logic [31:0] raddr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            pend = 0;
            gcnt = -1;
        end else begin
            if (pend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = memword(raddr);
                    pend = 0;
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata = $urandom;
                    rcnt--;
                end
            end else begin
                mem_rvalid = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                if (gcnt < 0) gcnt = (gnt_cfg >= 0) ? gnt_cfg : $urandom_range(0, 3);
                if (gcnt == 0) begin
                    mem_gnt = 1'b1;
                    gcnt = -1;
                    if (!mem_we) begin
                        pend = 1;
                        raddr = mem_addr;
                        rcnt = (rv_cfg >= 0) ? rv_cfg : $urandom_range(0, 3);
                    end
                end else begin
                    gcnt--;
                end
            end
        end
    end

    // Monitor
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (mem_req) begin
                if (reqq.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req), 32'd0);
                end else begin
                    chk("req_we", 32'(mem_we), 32'(reqq[0].we));
                    chk("req_addr", mem_addr, reqq[0].addr);
                    chk("req_be", 32'(mem_be), 32'(reqq[0].be));
                    if (reqq[0].we) chk("req_wdata", mem_wdata, reqq[0].wdata);
                    if (mem_gnt) void'(reqq.pop_front());
                end
            end
            if (wb_valid) begin
                if (wbq.size() == 0) begin
                    chk("unexpected_wb", 32'(wb_valid), 32'd0);
                end else begin
                    chk("wb_rd", 32'(wb_rd), 32'(wbq[0].rd));
                    chk("wb_data", wb_data, wbq[0].data);
                    void'(wbq.pop_front());
                end
            end
            if (fault) begin
                if (faultq.size() == 0) chk("unexpected_fault", 32'(fault), 32'd0);
                else begin
                    chk("fault", 32'(fault), 32'd1);
                    void'(faultq.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] r, output int acc);
        int b = 0;
        while (!ex_ready && b < 60) begin
            @(negedge clk);
            b++;
        end
        if (!ex_ready) begin
            chk("ex_ready_timeout", 32'(ex_ready), 32'd1);
            acc = -1;
            return;
        end
        ex_valid = 1'b1;
        MemRead = mr;
        MemWrite = mw;
        funct3 = f3;
        ALUResult = a;
        WriteData = wd;
        rd = r;
        @(posedge clk);
        acc = cyc;
        model(mr, mw, f3, a, wd, r);
        @(negedge clk);
        ex_valid = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic wait_wb(output int at);
        int b = 0;
        while (!wb_valid && b < 40) begin
            @(negedge clk);
            b++;
        end
        at = cyc;
        chk("wb_timeout", 32'(wb_valid), 32'd1);
    endtask

    initial begin
        int acc;
        int at;
        int n;
        int kind;
        logic [2:0] f3;
        repeat (3) @(negedge clk);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // lw with minimum latency
        mem[32'h100] = 32'hDEADBEEF;
        gnt_cfg = 0;
        rv_cfg = 0;
        issue(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, acc);
        chk("lw_req_t1", 32'(mem_req), 32'd1);
        wait_wb(at);
        chk("lw_latency", 32'(at - acc), 32'd3);

        // lb / lbu at byte lane 3
        @(negedge clk);
        mem[32'h100] = 32'h80FF1234;
        issue(1, 0, 3'b000, 32'h103, 32'h0, 5'd6, acc);
        wait_wb(at);
        chk("lb_data", wb_data, 32'hFFFFFF80);
        issue(1, 0, 3'b100, 32'h103, 32'h0, 5'd7, acc);
        wait_wb(at);
        chk("lbu_data", wb_data, 32'h00000080);

        // sh with stalled grant
        @(negedge clk);
        gnt_cfg = 3;
        issue(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, acc);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("sh_req_cycles", 32'(n), 32'd4);
        chk("sh_idle_after", 32'(ex_ready), 32'd1);
        gnt_cfg = 0;

        // faulting accesses
        issue(1, 0, 3'b010, 32'h102, 32'h0, 5'd3, acc);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_no_req", 32'(mem_req), 32'd0);
        chk("mis_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        chk("mis_fault_pulse", 32'(fault), 32'd0);
        issue(1, 0, 3'b011, 32'h100, 32'h0, 5'd3, acc);
        chk("f3_011_fault", 32'(fault), 32'd1);
        chk("f3_011_no_req", 32'(mem_req), 32'd0);
        @(negedge clk);

        // back-to-back: next lw accepted in the wb_valid cycle
        issue(1, 0, 3'b010, 32'h300, 32'h0, 5'd9, acc);
        wait_wb(at);
        issue(1, 0, 3'b010, 32'h304, 32'h0, 5'd0, acc);
        chk("b2b_accept", 32'(acc), 32'(at));
        wait_wb(at);
        @(negedge clk);

        // reset in the middle of a request
        gnt_cfg = 20;
        issue(0, 1, 3'b010, 32'h400, 32'h55AA55AA, 5'd0, acc);
        chk("rst_mid_req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
        reqq.delete();
        wbq.delete();
        faultq.delete();
        gnt_cfg = -1;
        rv_cfg = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(ex_ready), 32'd1);
        chk("rst_mid_wb", 32'(wb_valid), 32'd0);
        chk("rst_mid_req", 32'(mem_req), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 19);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                 : ((kind < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2)));
            if (kind < 9)
                issue(1, 0, f3, $urandom & 32'h3FF, $urandom, 5'($urandom), acc);
            else if (kind < 17)
                issue(0, 1, f3, $urandom & 32'h3FF, $urandom, 5'($urandom), acc);
            else if (kind < 19)
                issue(0, 0, f3, $urandom & 32'h3FF, $urandom, 5'($urandom), acc);
            else
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        n = 0;
        while ((reqq.size() != 0 || wbq.size() != 0 || faultq.size() != 0 || !ex_ready)
               && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_req", 32'(reqq.size()), 32'd0);
        chk("drain_wb", 32'(wbq.size()), 32'd0);
        chk("drain_fault", 32'(faultq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
